// File: rtl/sequence_datapath.sv
// rtl/sequence_datapath.sv - seed/LFSR colour sequence store, speed-scaled pulse timer, LED drive and move check
module sequence_datapath #(
  parameter int          BASE_TICKS   = 25_000_000,
  parameter int          STEP_TICKS   = 2_500_000,
  parameter int          MIN_TICKS    = 5_000_000,
  parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_seedgen,
  input  logic       start,
  input  logic       load_colour,
  input  logic       load_speed,
  input  logic       flash_clk,
  input  logic [5:0] current_round,
  input  logic [5:0] check_round,
  input  logic [2:0] speed,
  input  logic [3:0] player_input,
  output logic       pulse,
  output logic       result,
  output logic [3:0] leds,
  output logic [1:0] colour_dbg
);

  localparam logic [31:0] BASE = 32'(BASE_TICKS);
  localparam logic [31:0] STEP = 32'(STEP_TICKS);
  localparam logic [31:0] MINP = 32'(MIN_TICKS);

  logic [15:0] seed_cnt;
  logic [15:0] lfsr;
  logic [1:0]  seq [32];
  logic [2:0]  speed_reg;
  logic [31:0] tick_cnt;
  logic [31:0] speed_step;
  logic [31:0] period;
  logic [5:0]  rd_diff;
  logic [4:0]  rd_idx;
  logic        colour_en;
  logic        restart;
  logic        tick_last;
  logic        lfsr_fb;

  // A start in the same cycle wins; a full store (round 32) drops the request entirely.
  assign colour_en  = load_colour && !start && !current_round[5];
  assign restart    = load_speed || colour_en;
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rd_diff    = current_round - check_round;
  assign rd_idx     = rd_diff[4:0];
  assign colour_dbg = seq[rd_idx];

  // Compare before subtracting so the period never underflows below the floor.
  assign speed_step = {29'b0, speed_reg} * STEP;
  assign period     = (speed_step >= BASE - MINP) ? MINP : BASE - speed_step;
  assign tick_last  = (tick_cnt == period - 32'd1);

  always_ff @(posedge clk) begin
    if (reset || rst_seedgen) seed_cnt <= 16'd0;
    else                      seed_cnt <= seed_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)          lfsr <= LFSR_DEFAULT;
    else if (start)     lfsr <= (seed_cnt == 16'd0) ? LFSR_DEFAULT : seed_cnt;
    else if (colour_en) lfsr <= {lfsr[14:0], lfsr_fb};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) seq[i] <= 2'd0;
    end else if (colour_en) begin
      seq[current_round[4:0]] <= lfsr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           speed_reg <= 3'd0;
    else if (load_speed) speed_reg <= speed;
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      tick_cnt <= 32'd0;
      pulse    <= 1'b0;
    end else if (tick_last) begin
      tick_cnt <= 32'd0;
      pulse    <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
      pulse    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds   <= 4'b0000;
      result <= 1'b0;
    end else begin
      leds   <= flash_clk ? (4'b0001 << colour_dbg) : 4'b0000;
      result <= (player_input == (4'b0001 << colour_dbg));
    end
  end

endmodule
